// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
//   - geometry constants (offset/index/tag/word-select widths)
//   - state_t : miss sequencer states
//   - line_t  : one cache line (valid, tag, 128-bit block)
package icache_pkg;

  localparam int unsigned ICACHE_NUM_LINES = 8;
  localparam int unsigned ICACHE_ADDR_W    = 10;
  localparam int unsigned OFFSET_W         = 4;
  localparam int unsigned INDEX_W          = $clog2(ICACHE_NUM_LINES);
  localparam int unsigned TAG_W            = ICACHE_ADDR_W - OFFSET_W - INDEX_W;
  localparam int unsigned WORD_SEL_W       = 2;
  localparam int unsigned BLOCK_W          = 128;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    logic [BLOCK_W-1:0] data;
  } line_t;

endpackage

// File: rtl/icache_word_select.sv
// Picks one 32-bit instruction word out of a 128-bit cache block.
// Ports:
//   block    - 128-bit line data
//   word_sel - word index (0 selects bits [31:0], 3 selects [127:96])
//   word     - selected 32-bit word
module icache_word_select
  import icache_pkg::*;
(
  input  logic [BLOCK_W-1:0]    block,
  input  logic [WORD_SEL_W-1:0] word_sel,
  output logic [31:0]           word
);

  always_comb begin
    word = '0;
    case (word_sel)
      2'd0:    word = block[31:0];
      2'd1:    word = block[63:32];
      2'd2:    word = block[95:64];
      default: word = block[127:96];
    endcase
  end

endmodule

// File: rtl/instruction_cache_controller.sv
// Direct-mapped, read-only instruction cache with a miss sequencer.
// Zero-cycle hits; a miss stalls the CPU, reads one 16-byte block from
// instruction memory and fills the line, after which the fetch hits.
// Ports:
//   clock, reset      - clock, synchronous active-high reset
//   read, address     - CPU fetch request and byte address
//   instruction       - fetched word (holds last served value otherwise)
//   busywait          - CPU stall
//   mem_read          - block read request to instruction memory
//   mem_address       - block address {tag, index} of the pending miss
//   mem_readinst      - 128-bit block returned by memory
//   mem_busywait      - memory busy flag
//   hit_count,
//   miss_count        - saturating statistics, only when ICACHE_STATS_EN
//                       is defined
module instruction_cache_controller
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES    = 8,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned BLOCK_ADDR_W = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic [ADDR_W-1:0]       address,
  output logic [31:0]             instruction,
  output logic                    busywait,
  output logic                    mem_read,
  output logic [BLOCK_ADDR_W-1:0] mem_address,
  input  logic [BLOCK_W-1:0]      mem_readinst,
  input  logic                    mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]             hit_count,
  output logic [15:0]             miss_count
`endif
);

  state_t             state;
  line_t              lines [NUM_LINES];
  logic               issued;
  logic               rst_q;
  logic [TAG_W-1:0]   miss_tag;
  logic [INDEX_W-1:0] miss_idx;
  logic [31:0]        instr_q;

  logic [TAG_W-1:0]      cur_tag;
  logic [INDEX_W-1:0]    cur_idx;
  logic [WORD_SEL_W-1:0] cur_word;
  logic [1:0]            addr_unused;
  logic [31:0]           sel_word;
  logic                  hit;
  logic                  active;
  logic                  serve;
  logic                  miss;

  always_comb begin
    cur_tag     = address[ADDR_W-1 -: TAG_W];
    cur_idx     = address[OFFSET_W +: INDEX_W];
    cur_word    = address[2 +: WORD_SEL_W];
    addr_unused = address[1:0];
  end

  icache_word_select u_word_select (
    .block    (lines[cur_idx].data),
    .word_sel (cur_word),
    .word     (sel_word)
  );

  // The cycle after reset is held quiet (busywait low, no miss launched)
  // so the CPU sees a clean release before any stall.
  always_comb begin
    hit    = read & lines[cur_idx].valid & (lines[cur_idx].tag == cur_tag);
    active = (state == IDLE) & ~reset & ~rst_q;
    serve  = active & hit;
    miss   = active & read & ~hit;
  end

  always_comb begin
    busywait    = ~reset & ~rst_q & ((state != IDLE) | (read & ~hit));
    instruction = serve ? sel_word : instr_q;
    mem_read    = (state == MEM_READ);
    mem_address = {miss_tag, miss_idx};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      issued   <= 1'b0;
      rst_q    <= 1'b1;
      miss_tag <= '0;
      miss_idx <= '0;
      instr_q  <= '0;
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        lines[i].valid <= 1'b0;
      end
    end else begin
      rst_q  <= 1'b0;
      issued <= 1'b0;
      if (serve) begin
        instr_q <= sel_word;
      end
      unique case (state)
        IDLE: begin
          if (miss) begin
            state    <= MEM_READ;
            miss_tag <= cur_tag;
            miss_idx <= cur_idx;
          end
        end
        MEM_READ: begin
          // Memory raises mem_busywait only after seeing mem_read, so the
          // first request cycle can never complete the read.
          issued <= 1'b1;
          if (issued && !mem_busywait) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          lines[miss_idx] <= '{valid: 1'b1, tag: miss_tag, data: mem_readinst};
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [ADDR_W-1:0] pend_addr;
  logic [ADDR_W-1:0] last_hit_addr;
  logic              last_valid;

  // A completed fill records the missed address as the last hit address,
  // so the re-presented fetch that finishes a miss is not also a hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count     <= '0;
      miss_count    <= '0;
      pend_addr     <= '0;
      last_hit_addr <= '0;
      last_valid    <= 1'b0;
    end else begin
      if (miss) begin
        pend_addr <= address;
        if (miss_count != '1) begin
          miss_count <= miss_count + 16'd1;
        end
      end
      if (serve && (!last_valid || address != last_hit_addr)) begin
        last_hit_addr <= address;
        last_valid    <= 1'b1;
        if (hit_count != '1) begin
          hit_count <= hit_count + 16'd1;
        end
      end
      if (state == UPDATE) begin
        last_hit_addr <= pend_addr;
        last_valid    <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Self-checking bench for instruction_cache_controller: directed fetches
// with literal expectations, then randomized fetch/reset traffic compared
// each cycle against a transaction-level cache model and memory model.
module tb_instruction_cache_controller;

  logic         clock = 1'b0;
  logic         reset;
  logic         read;
  logic [9:0]   address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readinst = '0;
  logic         mem_busywait = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  instruction_cache_controller #(
    .NUM_LINES    (8),
    .ADDR_W       (10),
    .BLOCK_ADDR_W (6)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readinst (mem_readinst),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory image, 64 blocks of 16 bytes.
  logic [127:0] mem [64];

  // Cache model: contents per line plus the outstanding-miss timeline.
  logic         m_valid [8];
  logic [2:0]   m_tag   [8];
  logic [127:0] m_data  [8];
  int           rd_left  = 0;   // remaining cycles with mem_read high
  bit           upd      = 0;   // the fill cycle is the current cycle
  bit           post_rst = 0;
  bit           chk_en   = 0;
  logic [5:0]   m_blk    = '0;
  logic [31:0]  m_instr  = '0;
  int           lat      = 1;   // memory latency for the next miss

  // Memory model state.
  bit mb_busy   = 0;
  bit mb_served = 0;
  int mb_cnt    = 0;

  function automatic logic [31:0] mword(input logic [9:0] a);
    logic [127:0] d;
    d = m_data[a[6:4]];
    return d[a[3:2]*32 +: 32];
  endfunction

  bit          e_idle, e_hit, e_serve, e_bw, e_mr;
  logic [31:0] e_instr;

  always @(negedge clock) begin
    e_idle  = (rd_left == 0) && !upd;
    e_hit   = read && m_valid[address[6:4]] && (m_tag[address[6:4]] == address[9:7]);
    e_serve = e_idle && !reset && !post_rst && e_hit;
    e_instr = e_serve ? mword(address) : m_instr;
    e_bw    = !reset && !post_rst && (!e_idle || (read && !e_hit));
    e_mr    = (rd_left > 0);
    if (chk_en) begin
      check("busywait", {31'd0, busywait}, {31'd0, e_bw});
      check("mem_read", {31'd0, mem_read}, {31'd0, e_mr});
      check("instruction", instruction, e_instr);
      if (e_mr) check("mem_address", {26'd0, mem_address}, {26'd0, m_blk});
    end

    // Memory: busy for lat cycles after seeing mem_read, then data.
    if (mem_read !== 1'b1) begin
      mb_busy = 0; mb_served = 0; mem_busywait = 1'b0;
    end else if (!mb_busy && !mb_served) begin
      if (lat == 0) begin
        mem_readinst = mem[mem_address]; mb_served = 1;
      end else begin
        mb_busy = 1; mb_cnt = lat; mem_busywait = 1'b1;
      end
    end else if (mb_busy) begin
      mb_cnt--;
      if (mb_cnt == 0) begin
        mb_busy = 0; mb_served = 1; mem_busywait = 1'b0;
        mem_readinst = mem[mem_address];
      end
    end

    // Advance the cache model to the next cycle.
    if (reset) begin
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      rd_left = 0; upd = 0; post_rst = 1; m_instr = '0; chk_en = 1;
    end else begin
      if (rd_left > 0) begin
        rd_left--;
        if (rd_left == 0) upd = 1;
      end else if (upd) begin
        m_valid[m_blk[2:0]] = 1'b1;
        m_tag[m_blk[2:0]]   = m_blk[5:3];
        m_data[m_blk[2:0]]  = mem[m_blk];
        upd = 0;
      end else if (e_serve) begin
        m_instr = e_instr;
      end else if (e_idle && !post_rst && read && !e_hit) begin
        m_blk   = address[9:4];
        lat     = $urandom_range(0, 3);
        rd_left = ((lat < 1) ? 1 : lat) + 1;
      end
      post_rst = 0;
    end
  end

  task automatic fetch(input logic [9:0] a, output bit was_miss, output logic [5:0] seen);
    int n;
    was_miss = 0; seen = '0; n = 0;
    @(posedge clock); #1; read = 1'b1; address = a;
    forever begin
      @(negedge clock); #1;
      if (mem_read) begin was_miss = 1; seen = mem_address; end
      if (busywait) was_miss = 1;
      if (!busywait) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL fetch_timeout: busywait still 1 after %0d cycles, required 0", n);
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1; reset = 1'b1; read = 1'b0;
    @(posedge clock); #1; reset = 1'b0;
    @(posedge clock); #1;
  endtask

  bit         miss;
  logic [5:0] seen;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    mem[0][31:0]  = 32'h00000009;
    mem[0][63:32] = 32'h00010001;
    mem[1][31:0]  = 32'h08020001;
    reset = 1'b1; read = 1'b0; address = '0;
    repeat (3) @(posedge clock);
    #1; reset = 1'b0;
    @(negedge clock); #1;
    check("rst_busywait", {31'd0, busywait}, 32'd0);
    check("rst_instruction", instruction, 32'd0);
    @(posedge clock); #1;

    fetch(10'd0, miss, seen);
    check("a0_miss", {31'd0, miss}, 32'd1);
    check("a0_memaddr", {26'd0, seen}, 32'd0);
    check("a0_instr", instruction, 32'h00000009);
    fetch(10'd4, miss, seen);
    check("a4_hit", {31'd0, miss}, 32'd0);
    check("a4_instr", instruction, 32'h00010001);
    fetch(10'd16, miss, seen);
    check("a16_miss", {31'd0, miss}, 32'd1);
    check("a16_memaddr", {26'd0, seen}, 32'd1);
    check("a16_instr", instruction, 32'h08020001);
    fetch(10'd0, miss, seen);
    check("a0_rehit", {31'd0, miss}, 32'd0);
    check("a0_reinstr", instruction, 32'h00000009);
    fetch(10'd256, miss, seen);
    check("a256_miss", {31'd0, miss}, 32'd1);
    check("a256_memaddr", {26'd0, seen}, 32'd16);
    check("a256_instr", instruction, mem[16][31:0]);
    fetch(10'd0, miss, seen);
    check("a0_evicted", {31'd0, miss}, 32'd1);

    // Reset while the miss for address 512 is in MEM_READ.
    @(posedge clock); #1; read = 1'b1; address = 10'd512;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock); #1;
      if (mem_read) break;
    end
    check("mid_memread", {31'd0, mem_read}, 32'd1);
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0; read = 1'b0;
    @(negedge clock); #1;
    check("mid_rst_memread", {31'd0, mem_read}, 32'd0);
    @(posedge clock); #1;
    fetch(10'd16, miss, seen);
    check("a16_after_rst", {31'd0, miss}, 32'd1);

    do_reset();
    fetch(10'd0, miss, seen);
    fetch(10'd4, miss, seen);
    fetch(10'd8, miss, seen);
    fetch(10'd0, miss, seen);
    fetch(10'd16, miss, seen);
`ifdef ICACHE_STATS_EN
    @(posedge clock); #1; read = 1'b0;
    @(negedge clock); #1;
    check("miss_count", {16'd0, miss_count}, 32'd2);
    check("hit_count", {16'd0, hit_count}, 32'd3);
`endif

    // Random traffic: two tags only, so hits, conflicts and refills mix.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      reset = ($urandom_range(0, 299) == 0);
      read  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0)
        address = {3'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom)};
    end
    @(posedge clock); #1; reset = 1'b0; read = 1'b0;
    @(negedge clock); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
